// File: rtl/unidade_mult_div_pkg.sv
// Shared definitions for the multiply/divide unit: FSM states, opcode encodings
// and small opcode-decode helpers.
package unidade_mult_div_pkg;

   typedef enum logic [1:0] {
      Ocioso  = 2'd0,
      Prepara = 2'd1,
      Calcula = 2'd2,
      Corrige = 2'd3
   } estado_e;

   localparam logic [1:0] OpMult  = 2'b00;
   localparam logic [1:0] OpMultu = 2'b01;
   localparam logic [1:0] OpDiv   = 2'b10;
   localparam logic [1:0] OpDivu  = 2'b11;

   // Bit 0 clear selects the signed flavour of both MULT and DIV.
   function automatic logic op_com_sinal(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic op_divide(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/unidade_mult_div_corretor_sinal.sv
// Conditional two's-complement negation, shared by the operand-magnitude and
// result-correction steps of the multiply/divide unit.
module corretor_sinal #(
   parameter int unsigned Largura = 32
) (
   input  logic [Largura-1:0] valor_i,
   input  logic               nega_i,
   output logic [Largura-1:0] resultado_o
);

   localparam logic [Largura-1:0] Um = Largura'(1);

   always_comb begin
      resultado_o = valor_i;
      if (nega_i) begin
         resultado_o = ~valor_i + Um;
      end
   end

endmodule

// File: rtl/unidade_mult_div.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with private HI/LO registers; one result
// bit per cycle on unsigned magnitudes, sign fixed up in a final cycle.
module unidade_mult_div
   import unidade_mult_div_pkg::*;
(
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic [1:0]  Op,
   input  logic [31:0] OperandoA,
   input  logic [31:0] OperandoB,
   input  logic        EscreveHI,
   input  logic        EscreveLO,
   input  logic [31:0] DadoEscrita,
   output logic        Busy,
   output logic        Done,
   output logic        DivZero,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   estado_e     estado_q, estado_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] mag_a_q, mag_a_d;
   logic [31:0] mag_b_q, mag_b_d;
   logic        sinal_res_q, sinal_res_d;
   logic        sinal_resto_q, sinal_resto_d;
   logic [63:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;
   logic        div_zero_q, div_zero_d;

   logic [31:0] abs_a, abs_b;
   logic [63:0] prod_final;
   logic [31:0] quoc_final, resto_final;
   logic [32:0] soma_mult;
   logic [32:0] resto_desl;
   logic [32:0] tentativa;
   logic        subtrai;
   logic [31:0] resto_novo;

   corretor_sinal #(.Largura(32)) u_abs_a (
      .valor_i     (a_q),
      .nega_i      (op_com_sinal(op_q) & a_q[31]),
      .resultado_o (abs_a)
   );

   corretor_sinal #(.Largura(32)) u_abs_b (
      .valor_i     (b_q),
      .nega_i      (op_com_sinal(op_q) & b_q[31]),
      .resultado_o (abs_b)
   );

   corretor_sinal #(.Largura(64)) u_neg_prod (
      .valor_i     (acc_q),
      .nega_i      (sinal_res_q),
      .resultado_o (prod_final)
   );

   corretor_sinal #(.Largura(32)) u_neg_quoc (
      .valor_i     (acc_q[31:0]),
      .nega_i      (sinal_res_q),
      .resultado_o (quoc_final)
   );

   corretor_sinal #(.Largura(32)) u_neg_resto (
      .valor_i     (acc_q[63:32]),
      .nega_i      (sinal_resto_q),
      .resultado_o (resto_final)
   );

   // Multiply: add into the upper half, then shift the whole product right.
   assign soma_mult = {1'b0, acc_q[63:32]} + (mag_a_q[0] ? {1'b0, mag_b_q} : 33'd0);

   // Divide: partial remainder in acc[63:32], quotient bits enter acc[31:0].
   assign resto_desl = {acc_q[63:32], mag_a_q[31]};
   assign tentativa  = resto_desl - {1'b0, mag_b_q};
   assign subtrai    = resto_desl[32] | ~tentativa[32];
   assign resto_novo = subtrai ? tentativa[31:0] : resto_desl[31:0];

   always_comb begin
      estado_d      = estado_q;
      op_d          = op_q;
      a_d           = a_q;
      b_d           = b_q;
      mag_a_d       = mag_a_q;
      mag_b_d       = mag_b_q;
      sinal_res_d   = sinal_res_q;
      sinal_resto_d = sinal_resto_q;
      acc_d         = acc_q;
      cnt_d         = cnt_q;
      hi_d          = hi_q;
      lo_d          = lo_q;
      done_d        = 1'b0;
      div_zero_d    = 1'b0;

      unique case (estado_q)
         Ocioso: begin
            if (EscreveHI) hi_d = DadoEscrita;
            if (EscreveLO) lo_d = DadoEscrita;
            if (Start) begin
               op_d     = Op;
               a_d      = OperandoA;
               b_d      = OperandoB;
               estado_d = Prepara;
            end
         end
         Prepara: begin
            mag_a_d       = abs_a;
            mag_b_d       = abs_b;
            sinal_res_d   = op_com_sinal(op_q) & (a_q[31] ^ b_q[31]);
            sinal_resto_d = op_com_sinal(op_q) & a_q[31];
            acc_d         = 64'd0;
            cnt_d         = 5'd0;
            estado_d      = Calcula;
         end
         Calcula: begin
            if (op_divide(op_q)) begin
               acc_d   = {resto_novo, acc_q[30:0], subtrai};
               mag_a_d = {mag_a_q[30:0], 1'b0};
            end else begin
               acc_d   = {soma_mult, acc_q[31:1]};
               mag_a_d = {1'b0, mag_a_q[31:1]};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) estado_d = Corrige;
         end
         Corrige: begin
            done_d = 1'b1;
            if (op_divide(op_q)) begin
               if (b_q == 32'd0) begin
                  hi_d       = a_q;
                  lo_d       = 32'hFFFF_FFFF;
                  div_zero_d = 1'b1;
               end else begin
                  hi_d = resto_final;
                  lo_d = quoc_final;
               end
            end else begin
               hi_d = prod_final[63:32];
               lo_d = prod_final[31:0];
            end
            estado_d = Ocioso;
         end
         default: estado_d = Ocioso;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         estado_q      <= Ocioso;
         op_q          <= 2'b00;
         a_q           <= 32'd0;
         b_q           <= 32'd0;
         mag_a_q       <= 32'd0;
         mag_b_q       <= 32'd0;
         sinal_res_q   <= 1'b0;
         sinal_resto_q <= 1'b0;
         acc_q         <= 64'd0;
         cnt_q         <= 5'd0;
         hi_q          <= 32'd0;
         lo_q          <= 32'd0;
         done_q        <= 1'b0;
         div_zero_q    <= 1'b0;
      end else begin
         estado_q      <= estado_d;
         op_q          <= op_d;
         a_q           <= a_d;
         b_q           <= b_d;
         mag_a_q       <= mag_a_d;
         mag_b_q       <= mag_b_d;
         sinal_res_q   <= sinal_res_d;
         sinal_resto_q <= sinal_resto_d;
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         hi_q          <= hi_d;
         lo_q          <= lo_d;
         done_q        <= done_d;
         div_zero_q    <= div_zero_d;
      end
   end

   assign Busy    = (estado_q != Ocioso);
   assign Done    = done_q;
   assign DivZero = div_zero_q;
   assign HI      = hi_q;
   assign LO      = lo_q;

endmodule
